// File: rtl/host_csr_pkg.sv
// host_csr_pkg: shared constants and FSM state type for the host CSR responder.
package host_csr_pkg;
  localparam logic [11:0] TOHOST_ADDR   = 12'h780;
  localparam logic [11:0] FROMHOST_ADDR = 12'h781;
  localparam int          DATA_W        = 64;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/host_csr_responder.sv
// host_csr_responder: tohost/fromhost CSR pair served over a host req/resp handshake.
// Define HOST_CSR_CLEAR_ON_READ_EN to clear tohost when the host reads it.
module host_csr_responder
  import host_csr_pkg::*;
#(
  parameter logic [11:0] ADDR_TOHOST   = TOHOST_ADDR,
  parameter logic [11:0] ADDR_FROMHOST = FROMHOST_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_host_csr_req_valid,
  output logic              io_host_csr_req_ready,
  input  logic              io_host_csr_req_bits_rw,
  input  logic [11:0]       io_host_csr_req_bits_addr,
  input  logic [DATA_W-1:0] io_host_csr_req_bits_data,
  output logic              io_host_csr_resp_valid,
  input  logic              io_host_csr_resp_ready,
  output logic [DATA_W-1:0] io_host_csr_resp_bits,
  input  logic              core_tohost_wen,
  input  logic [DATA_W-1:0] core_tohost_wdata,
  output logic [DATA_W-1:0] core_fromhost,
  output logic [DATA_W-1:0] core_tohost
);
  state_t            state, state_nx;
  logic [DATA_W-1:0] tohost, fromhost, resp_q, tohost_nx, fromhost_nx, rd_val;
  logic              accept, hit_to, hit_from, rd_clr;
  assign accept   = io_host_csr_req_valid && state == IDLE;
  assign hit_to   = io_host_csr_req_bits_addr == ADDR_TOHOST;
  assign hit_from = io_host_csr_req_bits_addr == ADDR_FROMHOST;
  assign rd_val   = hit_to ? tohost : hit_from ? fromhost : '0;
`ifdef HOST_CSR_CLEAR_ON_READ_EN
  assign rd_clr = accept && !io_host_csr_req_bits_rw && hit_to;
`else
  assign rd_clr = 1'b0;
`endif
  always_comb begin
    state_nx = state == IDLE ? (io_host_csr_req_valid ? RESP : IDLE)
                             : (io_host_csr_resp_ready ? IDLE : RESP);
    io_host_csr_req_ready  = state == IDLE;
    io_host_csr_resp_valid = state == RESP;
  end
  // core write has priority over both host write and clear-on-read
  always_comb begin
    tohost_nx   = core_tohost_wen ? core_tohost_wdata
                : (accept && io_host_csr_req_bits_rw && hit_to) ? io_host_csr_req_bits_data
                : rd_clr ? '0 : tohost;
    fromhost_nx = (accept && io_host_csr_req_bits_rw && hit_from) ? io_host_csr_req_bits_data
                : fromhost;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tohost   <= '0;
      fromhost <= '0;
      resp_q   <= '0;
    end else begin
      state    <= state_nx;
      tohost   <= tohost_nx;
      fromhost <= fromhost_nx;
      if (accept) resp_q <= rd_val;
    end
  end
  assign io_host_csr_resp_bits = resp_q;
  assign core_tohost           = tohost;
  assign core_fromhost         = fromhost;
endmodule

// File: tb/tb_host_csr_responder.sv
// tb_host_csr_responder: directed and randomized host/core traffic checked against a register model.
module tb_host_csr_responder;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, req_rw = 0, resp_valid, resp_ready = 0;
  logic [11:0] req_addr = '0;
  logic [63:0] req_data = '0, resp_bits, core_wdata = '0, core_fromhost, core_tohost;
  logic        core_wen = 0;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] m_to = '0, m_from = '0;

  host_csr_responder dut (
    .clk(clk), .reset(reset),
    .io_host_csr_req_valid(req_valid), .io_host_csr_req_ready(req_ready),
    .io_host_csr_req_bits_rw(req_rw), .io_host_csr_req_bits_addr(req_addr),
    .io_host_csr_req_bits_data(req_data), .io_host_csr_resp_valid(resp_valid),
    .io_host_csr_resp_ready(resp_ready), .io_host_csr_resp_bits(resp_bits),
    .core_tohost_wen(core_wen), .core_tohost_wdata(core_wdata),
    .core_fromhost(core_fromhost), .core_tohost(core_tohost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [11:0] a);
    return a == 12'h780 ? m_to : a == 12'h781 ? m_from : 64'd0;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".tohost"}, core_tohost, m_to);
    check({tag, ".fromhost"}, core_fromhost, m_from);
  endtask

  task automatic core_write(input logic [63:0] d);
    @(negedge clk);
    core_wen = 1; core_wdata = d;
    @(negedge clk);
    core_wen = 0;
    m_to = d;
    check_regs("core_wr");
  endtask

  // one full host transaction; stall = cycles resp_ready is held low
  task automatic xact(input string tag, input logic rw, input logic [11:0] a, input logic [63:0] d,
                      input logic cw, input logic [63:0] cwd, input int stall);
    logic [63:0] old;
    @(negedge clk);
    check({tag, ".idle_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, ".idle_valid"}, {63'd0, resp_valid}, 64'd0);
    req_valid = 1; req_rw = rw; req_addr = a; req_data = d;
    core_wen = cw; core_wdata = cwd;
    old = model_rd(a);
    if (rw && a == 12'h780) m_to = d;
    if (rw && a == 12'h781) m_from = d;
`ifdef HOST_CSR_CLEAR_ON_READ_EN
    if (!rw && a == 12'h780) m_to = '0;
`endif
    if (cw) m_to = cwd;
    @(negedge clk);
    core_wen = 0;
    req_data = ~req_data;
    check({tag, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
    check({tag, ".resp_bits"}, resp_bits, old);
    check({tag, ".busy"}, {63'd0, req_ready}, 64'd0);
    check_regs(tag);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, {63'd0, resp_valid}, 64'd1);
      check({tag, ".hold_bits"}, resp_bits, old);
      check({tag, ".hold_ready"}, {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    req_valid = 0;
    check({tag, ".done_valid"}, {63'd0, resp_valid}, 64'd0);
    check({tag, ".done_ready"}, {63'd0, req_ready}, 64'd1);
    check_regs(tag);
  endtask

  initial begin
    logic [11:0] a;
    @(negedge clk);
    @(negedge clk);
    check("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst.req_ready", {63'd0, req_ready}, 64'd1);
    check("rst.resp_bits", resp_bits, 64'd0);
    check_regs("rst");
    reset = 0;
    core_write(64'h3);
    xact("rd_tohost", 0, 12'h780, 64'h0, 0, 0, 0);
    xact("wr_fromhost", 1, 12'h781, 64'h55, 0, 0, 0);
    xact("rd_fromhost", 0, 12'h781, 64'h0, 0, 0, 0);
    xact("stall5", 0, 12'h781, 64'h0, 0, 0, 5);
    xact("wr_collide", 1, 12'h780, 64'h7, 1, 64'h9, 0);
    xact("rd_unmapped", 0, 12'h123, 64'h0, 0, 0, 0);
    xact("wr_unmapped", 1, 12'h123, 64'hdead, 0, 0, 1);
    core_write(64'hA5A5);
    xact("rd_clr_collide", 0, 12'h780, 64'h0, 1, 64'h11, 0);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: a = 12'h780;
        1: a = 12'h781;
        default: a = 12'($urandom);
      endcase
      xact("rand", 1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
           {$urandom, $urandom}, $urandom_range(0, 3));
    end
    xact("pre_rst_wr", 1, 12'h781, 64'h1234, 0, 0, 0);
    @(negedge clk);
    req_valid = 1; req_rw = 0; req_addr = 12'h781;
    @(negedge clk);
    req_valid = 0;
    check("arst.pending", {63'd0, resp_valid}, 64'd1);
    reset = 1;
    m_to = '0; m_from = '0;
    #1;
    check("arst.resp_valid", {63'd0, resp_valid}, 64'd0);
    check("arst.req_ready", {63'd0, req_ready}, 64'd1);
    check("arst.resp_bits", resp_bits, 64'd0);
    check_regs("arst");
    @(negedge clk);
    reset = 0;
    resp_ready = 1;
    @(negedge clk);
    check("arst.no_resp", {63'd0, resp_valid}, 64'd0);
    check("arst.ready_after", {63'd0, req_ready}, 64'd1);
    check_regs("arst_after");
    resp_ready = 0;
    xact("post_rst", 0, 12'h781, 64'h0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
